// File: rtl/shift_engine.sv
// shift_engine: multi-cycle shift/rotate engine with valid/ready ports.
// Shifts one operand by at most STEP positions per enabled cycle and reports
// carry, SLA overflow and illegal-op flags alongside the result.
// Optional feature macro: SHIFT_ROTATE_EN (adds ROL/ROR; otherwise they are illegal).
module shift_engine #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_illegal
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SLA = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
`endif

    // STEP widened by one bit so STEP == WIDTH still compares correctly
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] value;
    logic [2:0]       op_r;
    logic [SHW-1:0]   remaining;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic             sign_r;

    logic             op_legal;
    logic             accept;
    logic [SHW-1:0]   step_amt;
    logic [WIDTH:0]   ext_left;
    logic [WIDTH:0]   ext_right;
    logic [WIDTH:0]   sra_fill;
    logic [WIDTH-1:0] sla_back;
    logic             ovf_step;
    logic [WIDTH-1:0] step_value;
    logic             step_carry;
`ifdef SHIFT_ROTATE_EN
    logic [2*WIDTH-1:0] rot_left;
    logic [2*WIDTH-1:0] rot_right;
`endif

    assign in_ready     = (state == IDLE) && enable;
    assign out_valid    = (state == DONE) && enable;
    assign accept       = in_valid && in_ready;
    assign out_data     = value;
    assign out_carry    = carry;
    assign out_overflow = overflow;
    assign out_illegal  = illegal;

    // Decode which opcodes this build supports
    always_comb begin
`ifdef SHIFT_ROTATE_EN
        op_legal = (op[2:1] != 2'b11);
`else
        op_legal = (op[2] == 1'b0);
`endif
    end

    // One step of the datapath: k = min(remaining, STEP), result and carry per op
    always_comb begin
        step_amt   = ({1'b0, remaining} > STEP_W) ? STEP_W[SHW-1:0] : remaining;
        ext_left   = {1'b0, value} << step_amt;
        sra_fill   = sign_r ? ~({(WIDTH+1){1'b1}} >> step_amt) : '0;
        ext_right  = ({value, 1'b0} >> step_amt) | ((op_r == OP_SRA) ? sra_fill : '0);
        sla_back   = WIDTH'($signed(ext_left[WIDTH-1:0]) >>> step_amt);
        ovf_step   = (sla_back != value);
        step_value = value;
        step_carry = 1'b0;
`ifdef SHIFT_ROTATE_EN
        rot_left   = {value, value} << step_amt;
        rot_right  = {value, value} >> step_amt;
`endif
        case (op_r)
            OP_SLL, OP_SLA: begin
                step_value = ext_left[WIDTH-1:0];
                step_carry = ext_left[WIDTH];
            end
            OP_SRL, OP_SRA: begin
                step_value = ext_right[WIDTH:1];
                step_carry = ext_right[0];
            end
`ifdef SHIFT_ROTATE_EN
            OP_ROL: begin
                step_value = rot_left[2*WIDTH-1:WIDTH];
                step_carry = rot_left[WIDTH];
            end
            OP_ROR: begin
                step_value = rot_right[WIDTH-1:0];
                step_carry = rot_right[WIDTH-1];
            end
`endif
            default: begin
                step_value = value;
                step_carry = 1'b0;
            end
        endcase
    end

    // State register, frozen while enable is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (amount != '0 && op_legal) ? RUN : DONE;
                end
            end
            RUN: begin
                if (remaining == step_amt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers: capture on accept, advance one step per RUN cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value     <= '0;
            op_r      <= '0;
            remaining <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            sign_r    <= 1'b0;
        end else if (enable) begin
            if (state == IDLE && accept) begin
                value     <= in_data;
                op_r      <= op;
                remaining <= amount;
                carry     <= 1'b0;
                overflow  <= 1'b0;
                illegal   <= !op_legal;
                sign_r    <= in_data[WIDTH-1];
            end else if (state == RUN) begin
                value     <= step_value;
                remaining <= remaining - step_amt;
                carry     <= step_carry;
                if (op_r == OP_SLA) begin
                    overflow <= overflow | ovf_step;
                end
            end
        end
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised, multi-cycle shift/rotate engine and successor to the single-cycle 32-bit shift unit in the ALU path. It accepts one operand per transaction over a valid/ready input port and shifts it by at most STEP positions per cycle. The result is presented on a valid/ready output port with carry, overflow and illegal-op flags. It sits beside the arithmetic ALU in the execute stage, under the `SHIFT_REG` instruction class.

## Interface
- WIDTH, 32, operand/result width; ≥ 2.
- STEP, 4, maximum shift positions per cycle; power of 2, 1..WIDTH.
- SHW, $clog2(WIDTH), derived; width of the shift amount.

- clock  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  clock enable; low freezes all state.
- in_valid  input  1  operand request.
- in_ready  output  1  engine can accept an operand.
- in_data  input  WIDTH  operand.
- op  input  3  operation: 000 SLL, 001 SLA, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 11x illegal.
- amount  input  SHW  shift count, 0..WIDTH-1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_carry  output  1  last bit shifted out.
- out_overflow  output  1  SLA sign-change flag.
- out_illegal  output  1  op was unsupported.

## Operation
- FSM states: IDLE, RUN, DONE.
  - On reset: IDLE, with out_data, out_carry, out_overflow and out_illegal = 0.
- in_ready = (state == IDLE) && enable.
- out_valid = (state == DONE) && enable.
- IDLE, when in_valid && in_ready:
  - Capture in_data, op and amount into working registers.
  - Clear carry and overflow.
  - Go to RUN if amount ≠ 0 and op is legal; otherwise go to DONE with out_data = in_data, carry 0, overflow 0, and out_illegal set iff op is illegal.
- RUN, each enabled cycle:
  - k = min(remaining, STEP).
  - Shift the working value by k; remaining -= k.
  - Go to DONE when remaining reaches 0.
- Per-operation result and carry:
  - SLL/SLA: zero fill. Carry = value[WIDTH-k] before the step.
  - SRL: zero fill. Carry = value[k-1] before the step.
  - SRA: fill with the original sign bit. Carry = value[k-1] before the step.
  - ROL: carry = result[0] after the step.
  - ROR: carry = result[WIDTH-1] after the step.
- SLA overflow is sticky. It is set if bits [WIDTH-1 : WIDTH-1-k] of the pre-step value are not all equal. Final value = 1 iff the original top amount+1 bits are not all equal. Overflow is 0 for all other ops.
- DONE: the output holds stable until out_valid && out_ready, then the FSM returns to IDLE.
  - in_ready stays 0 in RUN and DONE; there is no transaction overlap.
- enable low: all registers hold and both handshakes are masked. Resuming continues exactly where it stopped.
- Reset mid-RUN or mid-DONE aborts the transaction. Outputs return to reset values and no result is emitted.

## Timing
- Accept on edge N.
- amount = 0 or illegal op: out_valid is high after edge N.
- Otherwise out_valid is high after edge N + ceil(amount/STEP), counting enabled edges only.
- Minimum spacing between accepts is the RUN cycles + 1 DONE cycle + 1 IDLE cycle.
- Output flags update on the same edge as out_data. Everything is registered; in_ready and out_valid are decoded from state & enable.

## Configuration
- `SHIFT_ROTATE_EN` defined: ROL and ROR are implemented as specified above.
- `SHIFT_ROTATE_EN` undefined:
  - op 100 and op 101 are illegal.
  - Result = operand, carry 0, overflow 0, out_illegal = 1.
  - Zero-latency path straight to DONE.
  - The rotate datapath is removed.

## Test plan
- SRA, in_data = 0x8000_00F0, amount = 4 → out_data 0xF800_000F, carry 0, out_valid after edge N+1.
- SLL, in_data = 0x0000_0001, amount = 31 → 0x8000_0000, carry 0, 8 RUN cycles. SLL, in_data = 0xFFFF_FFFF, amount = 1 → 0xFFFF_FFFE, carry 1.
- SLA, in_data = 0x4000_0000, amount = 1 → 0x8000_0000, overflow 1. SLA, in_data = 0xC000_0000, amount = 1 → 0x8000_0000, overflow 0, carry 1.
- With the macro: ROR, in_data = 0x0000_0001, amount = 1 → 0x8000_0000, carry 1. Without the macro, the same request → 0x0000_0001, out_illegal 1.
- Hold out_ready = 0 for 5 cycles in DONE → out_valid, out_data and flags stay stable, in_ready stays 0. Handshake → IDLE on the next edge. Test amount = 0 → out_data = in_data after one edge.
- Drop enable for 3 cycles mid-RUN → the result is unchanged and its latency grows by 3. Assert reset mid-RUN → all outputs 0, no out_valid, in_ready = 1 after release.
